// File: rtl/controle_saida_caixa.sv
// Outlet-side controller for the water tank: accepts dispense requests, drives the
// outlet valve, enforces the level floor and pauses on erro. Optional watchdog: DRAIN_WATCHDOG_EN.
module controle_saida_caixa #(
  parameter int LEVEL_W     = 3,
  parameter int MIN_LEVEL   = 1,
  parameter int DRAIN_TICKS = 4,
  parameter int WD_TICKS    = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LEVEL_W-1:0] level,
  input  logic               lower,
  input  logic               erro,
  input  logic               req,
  input  logic [LEVEL_W-1:0] amount,
  output logic               ack,
  output logic               valve_s,
  output logic               busy,
  output logic               done,
  output logic               short_fill,
  output logic [LEVEL_W-1:0] dispensed,
  output logic               fault
);

  if (LEVEL_W < 1 || DRAIN_TICKS < 1 || DRAIN_TICKS > 255 || WD_TICKS < 1) begin : g_bad_param
    $error("controle_saida_caixa: parameter out of range");
  end

  localparam logic [LEVEL_W-1:0] MIN_L     = LEVEL_W'(MIN_LEVEL);
  localparam logic [7:0]         TICK_LAST = 8'(DRAIN_TICKS - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, PAUSE, FINISH} state_e;

  state_e             state_q, state_d;
  logic [7:0]         timer_q, timer_d;
  logic [LEVEL_W-1:0] amt_q, amt_d;
  logic [LEVEL_W-1:0] disp_q, disp_d;
  logic               short_q, short_d;
  logic               ack_q, ack_d;
  logic               valve_q, busy_q, done_q;
  logic               level_ok;
  logic               wd_trip;
  logic               fault_q;

  assign level_ok = (level > MIN_L) && lower;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    amt_d   = amt_q;
    disp_d  = disp_q;
    short_d = short_q;
    ack_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && (amount != '0) && !erro && level_ok && !fault_q) begin
          amt_d   = amount;
          disp_d  = '0;
          timer_d = '0;
          short_d = 1'b0;
          ack_d   = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The valve was open for this whole cycle, so it always counts,
        // even when erro sends us to PAUSE at its end.
        if (timer_q == TICK_LAST) begin
          timer_d = '0;
          if (disp_q != '1) disp_d = disp_q + LEVEL_W'(1);
        end else begin
          timer_d = timer_q + 8'd1;
        end
        if (erro) begin
          state_d = PAUSE;
        end else if (disp_d >= amt_q) begin
          state_d = FINISH;
          short_d = 1'b0;
        end else if (wd_trip || !level_ok) begin
          state_d = FINISH;
          short_d = 1'b1;
        end
      end
      PAUSE: begin
        if (!erro) begin
          if (disp_q >= amt_q) begin
            state_d = FINISH;
            short_d = 1'b0;
          end else if (level_ok) begin
            state_d = DRAIN;
          end else begin
            state_d = FINISH;
            short_d = 1'b1;
          end
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      amt_q   <= '0;
      disp_q  <= '0;
      short_q <= 1'b0;
      ack_q   <= 1'b0;
      valve_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      amt_q   <= amt_d;
      disp_q  <= disp_d;
      short_q <= short_d;
      ack_q   <= ack_d;
      valve_q <= (state_d == DRAIN);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == FINISH);
    end
  end

`ifdef DRAIN_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_TICKS + 1);

  logic [WD_W-1:0]    wd_q;
  logic [LEVEL_W-1:0] lvl_q;
  logic               lvl_drop;
  logic               wd_fire;

  assign lvl_drop = (level < lvl_q);
  assign wd_trip  = (state_q == DRAIN) && !lvl_drop && (wd_q == WD_W'(WD_TICKS - 1));
  // Trip only latches the fault when it is the exit actually taken.
  assign wd_fire  = wd_trip && !erro && (disp_d < amt_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_q    <= '0;
      lvl_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      lvl_q <= level;
      if (ack_d) wd_q <= '0;
      else if (state_q == DRAIN) wd_q <= (lvl_drop || wd_trip) ? '0 : wd_q + WD_W'(1);
      if (wd_fire) fault_q <= 1'b1;
    end
  end
`else
  assign wd_trip = 1'b0;
  assign fault_q = 1'b0;
`endif

  assign ack        = ack_q;
  assign valve_s    = valve_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign short_fill = short_q;
  assign dispensed  = disp_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_controle_saida_caixa.sv
// Randomized scoreboard bench for controle_saida_caixa: driver pushes the expected
// outcome of each dispense, a monitor checks it when done pulses.
module tb_controle_saida_caixa;
  localparam int LEVEL_W = 3;
  localparam int MINL    = 1;
  localparam int TICKS   = 4;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic [LEVEL_W-1:0] level = 3'd5;
  logic               lower = 1'b1;
  logic               erro  = 1'b0;
  logic               req   = 1'b0;
  logic [LEVEL_W-1:0] amount = '0;
  logic               ack, valve_s, busy, done, short_fill, fault;
  logic [LEVEL_W-1:0] dispensed;

  controle_saida_caixa #(.LEVEL_W(LEVEL_W), .MIN_LEVEL(MINL), .DRAIN_TICKS(TICKS), .WD_TICKS(16)) dut (
    .clock(clock), .reset(reset), .level(level), .lower(lower), .erro(erro),
    .req(req), .amount(amount), .ack(ack), .valve_s(valve_s), .busy(busy),
    .done(done), .short_fill(short_fill), .dispensed(dispensed), .fault(fault)
  );

  always #5 clock = ~clock;

  typedef struct {int disp; int shrt; int open;} exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int open_cnt = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp_v, $time);
    end
  endtask

  // Monitor: tracks open-valve cycles per request and checks each done against the queue.
  always @(negedge clock) begin
    if (reset) begin
      if (ack) open_cnt = 0;
      if (valve_s) open_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("dispensed", int'(dispensed), e.disp);
          chk("short_fill", int'(short_fill), e.shrt);
          chk("open_cycles", open_cnt, e.open);
          chk("busy_at_done", int'(busy), 1);
        end
      end
    end
  end

  // Reference outcome from the request plan: every open cycle drains 1/TICKS of a unit;
  // a floor hit in open cycle f stops after f+1 cycles unless the amount completes first.
  function automatic exp_t predict(input int a, input int mode, input int f);
    exp_t e;
    int c;
    e.disp = a; e.shrt = 0; e.open = TICKS * a;
    if (mode == 1) begin
      c = f + 1;
      if (c < TICKS * a) begin
        e.disp = c / TICKS; e.shrt = 1; e.open = c;
      end
    end
    return e;
  endfunction

  task automatic run_txn();
    int a, mode, f, p, k, hold, guard;
    bit set;
    a    = $urandom_range(7, 1);
    mode = $urandom_range(2, 0);
    f    = $urandom_range(TICKS * a + 1, 0);
    p    = $urandom_range(TICKS * a - 2, 0);
    sb.push_back(predict(a, mode, f));
    @(negedge clock);
    level = LEVEL_W'($urandom_range(7, 2)); lower = 1'b1; erro = 1'b0;
    req = 1'b1; amount = LEVEL_W'(a);
    @(negedge clock);
    chk("ack_latency", int'(ack), 1);
    req = 1'b0; amount = LEVEL_W'($urandom);
    if (!ack) begin
      void'(sb.pop_back());
      return;
    end
    k = 0; hold = 0; set = 1'b0; guard = 0;
    while (guard < 300) begin
      if (valve_s) k++;
      if (mode == 1 && !set && valve_s && k == f + 1) begin
        level = LEVEL_W'(MINL); set = 1'b1;
      end
      if (mode == 2 && !set && valve_s && k == p + 1) begin
        erro = 1'b1; set = 1'b1; hold = 6;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) erro = 1'b0;
      end
      if (done) break;
      @(negedge clock);
      guard++;
    end
    if (guard >= 300) chk("done_timeout", 0, 1);
    erro = 1'b0;
    level = 3'd6;
    @(negedge clock);
    chk("busy_drop", int'(busy), 0);
  endtask

  task automatic reject(input int kind);
    int bad;
    bad = 0;
    level = 3'd5; lower = 1'b1; amount = 3'd3;
    case (kind)
      0: amount = 3'd0;
      1: level = LEVEL_W'(MINL);
      default: lower = 1'b0;
    endcase
    req = 1'b1;
    repeat (20) begin
      @(negedge clock);
      if (ack || valve_s || done) bad++;
    end
    req = 1'b0; level = 3'd5; lower = 1'b1;
    chk($sformatf("reject_%0d", kind), bad, 0);
  endtask

  initial begin
    #3 reset = 1'b0;
    #1 chk("reset_outputs", int'({ack, valve_s, busy, done, short_fill, dispensed, fault}), 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Directed normal case: amount 2 -> 8 open cycles, full completion.
    begin
      exp_t e;
      e.disp = 2; e.shrt = 0; e.open = 8;
      sb.push_back(e);
      level = 3'd5; req = 1'b1; amount = 3'd2;
      @(negedge clock);
      chk("ack_directed", int'(ack), 1);
      req = 1'b0;
      repeat (12) @(negedge clock);
      chk("sb_drained_directed", sb.size(), 0);
    end

    for (int i = 0; i < 3; i++) reject(i);
    for (int i = 0; i < 40; i++) run_txn();

    // Reset in the middle of a drain: valve drops at once and no done follows.
    begin
      int dones;
      dones = 0;
      level = 3'd6; req = 1'b1; amount = 3'd7;
      @(negedge clock);
      chk("ack_before_reset", int'(ack), 1);
      req = 1'b0;
      repeat (5) @(negedge clock);
      reset = 1'b0;
      #1 chk("reset_valve", int'(valve_s), 0);
      chk("reset_mid_outputs", int'({ack, busy, done, short_fill, dispensed, fault}), 0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      repeat (12) begin
        @(negedge clock);
        if (done || valve_s) dones++;
      end
      chk("no_done_after_reset", dones, 0);
    end

`ifndef DRAIN_WATCHDOG_EN
    chk("fault_off", int'(fault), 0);
`endif
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/controle_saida_caixa.md
Name: controle_saida_caixa

Overview:
Outlet-side controller for the water tank; the counterpart of the tank fill/level counter. Accepts dispense requests (in level units) from the irrigation consumer via a req/ack handshake. Drives the outlet valve while enforcing a minimum-level floor and the low-level sensor. Honours the shared erro fault line by pausing and resuming.

Parameters:
LEVEL_W, 3, width of tank level input and amount fields
MIN_LEVEL, 1, level at or below which the outlet never opens and draining stops
DRAIN_TICKS, 4, clock cycles of open valve counted as one dispensed level unit (range 1..255)
WD_TICKS, 16, watchdog window in cycles (used only with DRAIN_WATCHDOG_EN)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
level  input  LEVEL_W  current tank level from the fill/level counter
lower  input  1  low sensor; 1 = water above sensor
erro  input  1  system fault; pauses all valve activity
req  input  1  dispense request; held high with amount stable until ack
amount  input  LEVEL_W  level units to dispense; 0 is invalid
ack  output  1  one-cycle pulse when req is accepted
valve_s  output  1  outlet valve drive; 1 = open
busy  output  1  high from ack through done
done  output  1  one-cycle completion pulse
short_fill  output  1  valid with done; 1 = stopped before full amount
dispensed  output  LEVEL_W  units dispensed in current/last request
fault  output  1  watchdog trip flag (0 when feature absent)

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; tick timer 0; latched amount 0.
- States: IDLE, DRAIN, PAUSE, FINISH.
- IDLE: accept when req=1, amount!=0, erro=0, level>MIN_LEVEL, lower=1. Same cycle: latch amount, clear dispensed, clear timer; next edge: ack=1 (one cycle), busy=1, valve_s=1, state DRAIN. Otherwise ack stays 0 and req may stay pending indefinitely.
- req rejected conditions (amount=0, level<=MIN_LEVEL, lower=0) produce no ack and no done.
- DRAIN: valve_s=1; timer increments each cycle. On timer==DRAIN_TICKS-1: timer wraps to 0, dispensed increments (saturating at 2^LEVEL_W-1).
- DRAIN exit priority, evaluated each cycle: (1) erro=1 -> PAUSE. (2) dispensed reaches latched amount -> FINISH, short_fill=0. (3) level<=MIN_LEVEL or lower=0 -> FINISH, short_fill=1.
- Valve closes (valve_s=0) on the same edge that enters PAUSE or FINISH.
- Simultaneous final tick and level floor: full-amount completion wins, short_fill=0.
- PAUSE: valve_s=0; timer and dispensed hold; busy stays 1. When erro=0: return to DRAIN if level>MIN_LEVEL and lower=1, else FINISH with short_fill=1.
- FINISH: done=1 for exactly one cycle; short_fill valid same cycle; busy drops with done. Then IDLE. dispensed holds until the next accept.
- A new req is not sampled until IDLE (earliest one cycle after done).
- Reset mid-operation closes the valve immediately (async) and produces no done.
- Outputs are registered; no combinational path from inputs to valve_s.

Optional Feature:
DRAIN_WATCHDOG_EN
- Defined: in DRAIN, a counter tracks cycles since the last change of level. If WD_TICKS cycles pass with valve open and no level decrease: fault=1 (sticky until reset), go to FINISH with short_fill=1, and reject all further req.
- Undefined: no watchdog logic; fault tied to 0.

Test Plan:
- Reset: hold reset=0 mid-DRAIN -> valve_s=0 immediately; all outputs 0; no done pulse after release.
- Normal: level=5, lower=1, req with amount=2 (DRAIN_TICKS=4) -> ack one cycle later; valve_s high 8 cycles; dispensed=2; done=1 with short_fill=0.
- Floor: level=3, amount=5, force level to 1 after 5 cycles -> valve_s falls that edge; done with short_fill=1; dispensed=1.
- Pause: erro=1 for 6 cycles mid-unit -> valve_s=0, timer and dispensed frozen; after erro=0, resume with total open time still 4*amount.
- Reject: amount=0, or level=1, or lower=0 with req=1 for 20 cycles -> ack, valve_s and done stay 0.
- Watchdog (DRAIN_WATCHDOG_EN, WD_TICKS=16): level held constant with valve open -> fault=1 at cycle 16; done with short_fill=1; next req ignored.
